bp_be_fma_sched: RTL and testbench
==================================

# bp_be_fma_sched

Issue scheduler and scoreboard for the shared fused multiply-add unit, which serves both FP ops (FMA, latency 5) and integer multiply (imul, latency 4). It sits between the dispatch stage and the FMA pipe. It gates issue on writeback-slot conflicts between the two latencies and on RAW/WAW hazards against in-flight destinations. It tracks every in-flight op by age, kills young ops on flush, and emits writeback metadata aligned to the pipe's valid outputs.

## Interface
- `imul_latency_p`, 4: cycles from accepted issue to imul writeback.
- `fma_latency_p`, 5: cycles from accepted issue to FMA writeback. Must be greater than `imul_latency_p`.
- `flush_depth_p`, 2: ops younger than this age, in cycles, are killed by flush.
- `reg_addr_width_p`, 5: register address width.
- `clk_i` input 1: the single clock.
- `reset_n_i` input 1: reset, synchronous and active-low.
- `issue_v_i` input 1: an issue request is present.
- `issue_imul_i` input 1: 1 = imul (integer rd), 0 = FMA-class op (fp rd).
- `issue_rd_addr_i` input `reg_addr_width_p`: destination register.
- `issue_rs_v_i` input 3: source valid, for rs1/rs2/rs3.
- `issue_rs_fp_i` input 3: per source, 1 = fp regfile, 0 = int regfile.
- `issue_rs_addr_i` input 3*`reg_addr_width_p`: source addresses; rs1 occupies the LSBs.
- `issue_ready_o` output 1: combinational; the request is accepted when `issue_v_i & issue_ready_o & ~flush_i`.
- `flush_i` input 1: kill young in-flight ops.
- `wb_v_o` output 1: an op completes this cycle. Coincides with the pipe's `imul_v_o` / `fma_v_o`.
- `wb_imul_o` output 1: the completing op is an imul.
- `wb_rd_addr_o` output `reg_addr_width_p`: destination of the completing op.
- `idle_o` output 1: no live in-flight entries.

## Operation
- **State:** an age-indexed entry array for ages 1..`fma_latency_p`. Each entry holds {v, imul, rd_fp, rd_addr}.
- **Shift:** every cycle, entry[a] moves to entry[a+1]. An accepted issue writes entry[1] in the next cycle.
- **Completion:**
  - A live imul entry at age `imul_latency_p` drives the wb outputs and is dropped; it is not shifted further.
  - A live FMA entry at age `fma_latency_p` drives the wb outputs and is dropped.
- **Slot conflict:** an imul request is not ready when entry[`fma_latency_p`-`imul_latency_p`] holds a live FMA, because both would write back in the same cycle. FMA requests never slot-conflict. This guarantees at most one `wb_v_o` per cycle.
- **RAW hazard:** not ready if any valid source matches the {rd_fp, rd_addr} of any live entry, including an entry in its writeback cycle. There is no bypass.
- **WAW hazard:** not ready if {rd_fp, rd_addr} of the request matches a live entry.
- **Register x0:**
  - An int rd of 0 is never recorded for hazards. The entry is still tracked for wb.
  - An int source of 0 never matches.
  - fp f0 is an ordinary register.
- **Readiness:** `issue_ready_o` = ~slot_conflict & ~raw & ~waw. It is independent of `issue_v_i` and `flush_i`.
- **Flush:**
  - In the cycle `flush_i` is high, entries with age < `flush_depth_p` are cleared. With the default of 2, that is entry[1].
  - A same-cycle issue is not recorded.
  - Older entries proceed and write back normally.
  - A flush coincident with a wb does not suppress that wb.
- **Idle:** `idle_o` = no live entry.

## Timing
- An issue accepted in cycle t writes back in cycle t+`imul_latency_p` (imul) or t+`fma_latency_p` (FMA). Issue throughput is 1 per cycle.
- All wb outputs are registered-state driven, with no combinational path from issue inputs.
- `issue_ready_o` is combinational from the issue inputs and the entry array.
- **Reset:** while `reset_n_i`=0 at a clock edge, all entries are cleared.
  - The next cycle shows `wb_v_o`=0, `wb_imul_o`=0, `wb_rd_addr_o`=0, `idle_o`=1, and `issue_ready_o`=1 (no hazards).
  - Reset mid-flight drops every in-flight op silently.
  - An issue during reset is ignored.

## Structure
- The entry struct `bp_be_fma_sched_entry_s` and the latency constants belong in `bp_be_pkg`.
- Sub-module `bp_be_fma_hazard_match`: compares 3 sources plus rd against one entry and returns raw/waw bits. It is instantiated once per age.
- Include an assertion that `fma_latency_p` > `imul_latency_p` and a one-hot check on wb.

## Test plan
- **Slot conflict:** FMA rd f1 accepted in cycle 0; imul rd x3 requested in cycle 1 → `issue_ready_o`=0 in cycle 1, accepted in cycle 2. `wb_v_o` fires in cycle 5 (f1) and cycle 6 (x3, `wb_imul_o`=1).
- **RAW stall:** imul rd x5 in cycle 0; imul rs1=x5 requested from cycle 1 → not ready in cycles 1–4, wb x5 in cycle 4, accepted in cycle 5.
- **x0 and WAW:**
  - imul rd x0 in cycle 0, then imul rs1=x0 in cycle 1 → accepted in cycle 1.
  - FMA rd f2 in cycle 0, then FMA rd f2 → stalled until cycle 6.
- **Flush:** FMAs rd f1 (cycle 0) and f2 (cycle 1); flush plus issue f3 in cycle 2 → only f1 writes back (cycle 5); f2 and f3 never write back; `idle_o`=1 from cycle 6.
- **Reset:** FMA rd f4 in cycle 0; `reset_n_i`=0 in cycle 2 → no `wb_v_o` in cycles 3–8; `idle_o`=1 and `issue_ready_o`=1 in cycle 3.
- **Throughput:** independent FMAs rd f1..f4 in cycles 0–3 → wb in cycles 5–8 in order, with `wb_rd_addr_o`=1,2,3,4.

Source files
------------

// File: rtl/bp_be_pkg.sv
// bp_be_pkg
// Shared types and constants for the backend FMA issue scheduler.
//   - latency / flush-depth / register-width constants used as parameter defaults
//   - bp_be_fma_sched_entry_s: one in-flight op, tracked by age
//   - entry_tracked(): whether an entry's destination takes part in hazard checks
package bp_be_pkg;

    localparam int bp_imul_latency_lp   = 4;
    localparam int bp_fma_latency_lp    = 5;
    localparam int bp_flush_depth_lp    = 2;
    localparam int bp_reg_addr_width_lp = 5;

    typedef struct packed {
        logic                            v;
        logic                            imul;
        logic                            rd_fp;
        logic [bp_reg_addr_width_lp-1:0] rd_addr;
    } bp_be_fma_sched_entry_s;

    // Integer x0 is hardwired to zero, so an op writing it can never be the
    // producer of a hazard. fp f0 is an ordinary register and always tracks.
    function automatic logic entry_tracked(input bp_be_fma_sched_entry_s e);
        return e.v & (e.rd_fp | (e.rd_addr != '0));
    endfunction

endpackage

// File: rtl/bp_be_fma_hazard_match.sv
// bp_be_fma_hazard_match
// Compares one issue request against one in-flight entry.
// Ports:
//   rs_v, rs_fp, rs_addr : the three request sources (rs1 in the LSBs)
//   rd_fp, rd_addr       : the request destination
//   entry                : the in-flight entry at one age
//   raw, waw             : source/destination collides with the entry's rd
module bp_be_fma_hazard_match
    import bp_be_pkg::*;
#(
    parameter int reg_addr_width_p = bp_reg_addr_width_lp
)(
    input  logic [2:0]                    rs_v,
    input  logic [2:0]                    rs_fp,
    input  logic [3*reg_addr_width_p-1:0] rs_addr,
    input  logic                          rd_fp,
    input  logic [reg_addr_width_p-1:0]   rd_addr,
    input  bp_be_fma_sched_entry_s        entry,
    output logic                          raw,
    output logic                          waw
);

    logic tracked;

    assign tracked = entry_tracked(entry);

    // An int source of x0 can only equal an entry with int rd x0, and such
    // entries are never tracked, so x0 sources never match.
    // NOTE: raw gets a default before the loop so every path assigns it and
    // no latch is inferred.
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rs_v[i] && (rs_fp[i] == entry.rd_fp)
                && (rs_addr[i*reg_addr_width_p +: reg_addr_width_p] == entry.rd_addr)) begin
                raw = 1'b1;
            end
        end
        raw = raw & tracked;
    end

    assign waw = tracked & (rd_fp == entry.rd_fp) & (rd_addr == entry.rd_addr);

endmodule

// File: rtl/bp_be_fma_sched.sv
// bp_be_fma_sched
// Issue scheduler and scoreboard for the shared FMA/imul pipe.
// Ports:
//   clk_i, reset_n_i      : clock, synchronous active-low reset
//   issue_*_i             : issue request (type, rd, three sources)
//   issue_ready_o         : combinational; no slot conflict and no RAW/WAW hazard
//   flush_i               : kill ops younger than flush_depth_p cycles
//   wb_v_o, wb_imul_o,
//   wb_rd_addr_o          : metadata of the op completing this cycle
//   idle_o                : no live in-flight entries
module bp_be_fma_sched
    import bp_be_pkg::*;
#(
    parameter int imul_latency_p   = bp_imul_latency_lp,
    parameter int fma_latency_p    = bp_fma_latency_lp,
    parameter int flush_depth_p    = bp_flush_depth_lp,
    parameter int reg_addr_width_p = bp_reg_addr_width_lp
)(
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          issue_v_i,
    input  logic                          issue_imul_i,
    input  logic [reg_addr_width_p-1:0]   issue_rd_addr_i,
    input  logic [2:0]                    issue_rs_v_i,
    input  logic [2:0]                    issue_rs_fp_i,
    input  logic [3*reg_addr_width_p-1:0] issue_rs_addr_i,
    output logic                          issue_ready_o,
    input  logic                          flush_i,
    output logic                          wb_v_o,
    output logic                          wb_imul_o,
    output logic [reg_addr_width_p-1:0]   wb_rd_addr_o,
    output logic                          idle_o
);

    // An FMA at this age finishes in the same cycle an imul issued now would.
    localparam int conflict_age_lp = fma_latency_p - imul_latency_p;

    bp_be_fma_sched_entry_s entries [1:fma_latency_p];
    bp_be_fma_sched_entry_s issue_entry;
    logic [fma_latency_p:1] raw_vec;
    logic [fma_latency_p:1] waw_vec;
    logic                   slot_conflict;
    logic                   accept;
    logic                   imul_done;
    logic                   fma_done;

    // Hazard comparators, one per age. An entry in its writeback cycle still
    // counts: there is no bypass.
    for (genvar a = 1; a <= fma_latency_p; a++) begin : g_age
        bp_be_fma_hazard_match #(
            .reg_addr_width_p(reg_addr_width_p)
        ) u_match (
            .rs_v    (issue_rs_v_i),
            .rs_fp   (issue_rs_fp_i),
            .rs_addr (issue_rs_addr_i),
            .rd_fp   (~issue_imul_i),
            .rd_addr (issue_rd_addr_i),
            .entry   (entries[a]),
            .raw     (raw_vec[a]),
            .waw     (waw_vec[a])
        );
    end

    assign slot_conflict = issue_imul_i
                         & entries[conflict_age_lp].v
                         & ~entries[conflict_age_lp].imul;
    assign issue_ready_o = ~slot_conflict & ~(|raw_vec) & ~(|waw_vec);
    assign accept        = issue_v_i & issue_ready_o & ~flush_i;

    always_comb begin
        issue_entry         = '0;
        issue_entry.v       = 1'b1;
        issue_entry.imul    = issue_imul_i;
        issue_entry.rd_fp   = ~issue_imul_i;
        issue_entry.rd_addr = issue_rd_addr_i;
    end

    // Writeback is decoded purely from the entry registers.
    assign imul_done = entries[imul_latency_p].v & entries[imul_latency_p].imul;
    assign fma_done  = entries[fma_latency_p].v & ~entries[fma_latency_p].imul;

    always_comb begin
        wb_v_o       = imul_done | fma_done;
        wb_imul_o    = imul_done;
        wb_rd_addr_o = '0;
        if (imul_done) begin
            wb_rd_addr_o = entries[imul_latency_p].rd_addr;
        end else if (fma_done) begin
            wb_rd_addr_o = entries[fma_latency_p].rd_addr;
        end
    end

    always_comb begin
        idle_o = 1'b1;
        for (int a = 1; a <= fma_latency_p; a++) begin
            if (entries[a].v) begin
                idle_o = 1'b0;
            end
        end
    end

    // NOTE: non-blocking assignments let every age read its neighbour's
    // pre-edge value; blocking ones would ripple an op through all ages at once.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            // NOTE: the whole entry array is reset, not just the valid bits,
            // so nothing stale can reach the wb outputs after reset.
            for (int a = 1; a <= fma_latency_p; a++) begin
                entries[a] <= '0;
            end
        end else begin
            entries[1] <= accept ? issue_entry : '0;
            for (int a = 1; a < fma_latency_p; a++) begin
                // Young ops die on flush; an imul retires at its own latency.
                if ((flush_i && (a < flush_depth_p))
                    || ((a == imul_latency_p) && entries[a].imul)) begin
                    entries[a+1] <= '0;
                end else begin
                    entries[a+1] <= entries[a];
                end
            end
        end
    end

    a_latency_order: assert property (@(posedge clk_i) fma_latency_p > imul_latency_p)
        else $error("fma_latency_p must exceed imul_latency_p");

    a_wb_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                  $onehot0({imul_done, fma_done}))
        else $error("two ops completing in the same cycle");

endmodule

// File: tb/tb_bp_be_fma_sched.sv
// tb_bp_be_fma_sched
// Table-driven bench for bp_be_fma_sched. Each table row is one clock cycle of
// issue/flush/reset stimulus plus the expected ready/idle values; writebacks
// are predicted by a scoreboard queue filled as the bench issues ops.
module tb_bp_be_fma_sched;

    localparam int IMUL_LAT    = 4;
    localparam int FMA_LAT     = 5;
    localparam int FLUSH_DEPTH = 2;
    localparam int AW          = 5;

    typedef struct {
        logic        v;
        logic        imul;
        logic [4:0]  rd;
        logic [2:0]  rs_v;
        logic [2:0]  rs_fp;
        logic [14:0] rs_addr;
        logic        flush;
        logic        rst_n;
        int          exp_ready;   // -1: not checked
        int          exp_idle;    // -1: not checked
    } vec_t;

    typedef struct {
        int         due;
        int         issued;
        logic       imul;
        logic [4:0] rd;
    } sb_t;

    logic          clk;
    logic          reset_n;
    logic          issue_v;
    logic          issue_imul;
    logic [AW-1:0] issue_rd_addr;
    logic [2:0]    issue_rs_v;
    logic [2:0]    issue_rs_fp;
    logic [14:0]   issue_rs_addr;
    logic          issue_ready;
    logic          flush;
    logic          wb_v;
    logic          wb_imul;
    logic [AW-1:0] wb_rd_addr;
    logic          idle;

    vec_t vecs[$];
    sb_t  sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    bp_be_fma_sched #(
        .imul_latency_p   (IMUL_LAT),
        .fma_latency_p    (FMA_LAT),
        .flush_depth_p    (FLUSH_DEPTH),
        .reg_addr_width_p (AW)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .issue_v_i       (issue_v),
        .issue_imul_i    (issue_imul),
        .issue_rd_addr_i (issue_rd_addr),
        .issue_rs_v_i    (issue_rs_v),
        .issue_rs_fp_i   (issue_rs_fp),
        .issue_rs_addr_i (issue_rs_addr),
        .issue_ready_o   (issue_ready),
        .flush_i         (flush),
        .wb_v_o          (wb_v),
        .wb_imul_o       (wb_imul),
        .wb_rd_addr_o    (wb_rd_addr),
        .idle_o          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic imul, input logic [4:0] rd,
                                input logic [2:0] rs_v, input logic [2:0] rs_fp,
                                input logic [14:0] rs_addr, input logic fl, input logic rst_n,
                                input int exp_ready, input int exp_idle);
        vec_t r;
        r.v = v; r.imul = imul; r.rd = rd;
        r.rs_v = rs_v; r.rs_fp = rs_fp; r.rs_addr = rs_addr;
        r.flush = fl; r.rst_n = rst_n;
        r.exp_ready = exp_ready; r.exp_idle = exp_idle;
        return r;
    endfunction

    task automatic add(input logic v, input logic imul, input logic [4:0] rd,
                       input logic [2:0] rs_v, input logic [2:0] rs_fp,
                       input logic [14:0] rs_addr, input logic fl, input logic rst_n,
                       input int exp_ready, input int exp_idle);
        vecs.push_back(mk(v, imul, rd, rs_v, rs_fp, rs_addr, fl, rst_n, exp_ready, exp_idle));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 1, -1, -1);
    endtask

    // Drive one row after the rising edge, check before the next one, then
    // advance the scoreboard by what that next edge will do.
    task automatic step(input vec_t r);
        int  idx;
        sb_t e;
        @(posedge clk);
        #1;
        reset_n       = r.rst_n;
        issue_v       = r.v;
        issue_imul    = r.imul;
        issue_rd_addr = r.rd;
        issue_rs_v    = r.rs_v;
        issue_rs_fp   = r.rs_fp;
        issue_rs_addr = r.rs_addr;
        flush         = r.flush;
        @(negedge clk);
        if (r.exp_ready >= 0) check("issue_ready", 32'(issue_ready), 32'(r.exp_ready));
        if (r.exp_idle >= 0)  check("idle", 32'(idle), 32'(r.exp_idle));
        idx = -1;
        foreach (sb[i]) if (sb[i].due == cyc) idx = i;
        if (idx >= 0) begin
            check("wb", 32'({wb_v, wb_imul, wb_rd_addr}), 32'({1'b1, sb[idx].imul, sb[idx].rd}));
            sb.delete(idx);
        end else begin
            check("wb_v_quiet", 32'(wb_v), 32'(0));
        end
        if (!r.rst_n) begin
            sb.delete();
        end else begin
            if (r.flush) begin
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (cyc - sb[i].issued < FLUSH_DEPTH) sb.delete(i);
                end
            end
            if (r.v && (r.exp_ready == 1) && !r.flush) begin
                e.due    = cyc + (r.imul ? IMUL_LAT : FMA_LAT);
                e.issued = cyc;
                e.imul   = r.imul;
                e.rd     = r.rd;
                sb.push_back(e);
            end
        end
        cyc++;
    endtask

    initial begin
        reset_n = 1'b0; issue_v = 1'b0; issue_imul = 1'b0; issue_rd_addr = '0;
        issue_rs_v = '0; issue_rs_fp = '0; issue_rs_addr = '0; flush = 1'b0;
        cyc = 0; n_checks = 0; n_pass = 0;

        // ---- table: args are v, imul, rd, rs_v, rs_fp, rs_addr, flush, rst_n, ready, idle
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, 1, 1);            // post-reset state

        // Slot conflict: FMA f1, then imul x3 blocked one cycle
        add(1, 0, 1, 3'b000, 3'b000, 15'd0, 0, 1, 1, 1);
        add(1, 1, 3, 3'b000, 3'b000, 15'd0, 0, 1, 0, 0);
        add(1, 1, 3, 3'b000, 3'b000, 15'd0, 0, 1, 1, -1);
        gap(3);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 0);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 1);

        // RAW: imul x5, then imul reading x5 stalls through x5's wb cycle
        add(1, 1, 5, 3'b000, 3'b000, 15'd0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) add(1, 1, 6, 3'b001, 3'b000, 15'd5, 0, 1, 0, 0);
        add(1, 1, 6, 3'b001, 3'b000, 15'd5, 0, 1, 1, 1);
        gap(4);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 1);

        // x0 never matches; f0 is an ordinary register
        add(1, 1, 0, 3'b000, 3'b000, 15'd0, 0, 1, 1, 1);
        add(1, 1, 7, 3'b001, 3'b000, 15'd0, 0, 1, 1, -1);
        add(1, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, 1, -1);
        for (int i = 0; i < 5; i++) add(1, 0, 8, 3'b001, 3'b001, 15'd0, 0, 1, 0, -1);
        add(1, 0, 8, 3'b001, 3'b001, 15'd0, 0, 1, 1, -1);
        gap(5);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 1);

        // WAW: FMA f2 twice; second waits until the first has written back
        add(1, 0, 2, 3'b000, 3'b000, 15'd0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) add(1, 0, 2, 3'b000, 3'b000, 15'd0, 0, 1, 0, 0);
        add(1, 0, 2, 3'b000, 3'b000, 15'd0, 0, 1, 1, 1);
        gap(5);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 1);

        // Flush: f1 survives, f2 (age 1) and same-cycle f3 die
        add(1, 0, 1, 3'b000, 3'b000, 15'd0, 0, 1, 1, 1);
        add(1, 0, 2, 3'b000, 3'b000, 15'd0, 0, 1, 1, 0);
        add(1, 0, 3, 3'b000, 3'b000, 15'd0, 1, 1, 1, 0);
        gap(2);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 0);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 1);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 1);

        // Flush in the wb cycle of an old op does not suppress it
        add(1, 0, 9, 3'b000, 3'b000, 15'd0, 0, 1, 1, 1);
        gap(4);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 1, 1, -1, 0);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 1);

        // Int source x10 does not collide with in-flight fp f10
        add(1, 0, 10, 3'b000, 3'b000, 15'd0, 0, 1, 1, 1);
        gap(1);
        add(1, 1, 11, 3'b001, 3'b000, 15'd10, 0, 1, 1, 0);
        gap(4);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 1);

        // Throughput: four back-to-back independent FMAs
        for (int k = 1; k <= 4; k++) add(1, 0, 5'(k), 3'b000, 3'b000, 15'd0, 0, 1, 1, (k == 1) ? 1 : -1);
        gap(4);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 0);
        add(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 1);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) step(vecs[i]);

        // Reset mid-flight: f4 in flight, issue of f5 during reset is ignored
        step(mk(1, 0, 4, 3'b000, 3'b000, 15'd0, 0, 1, 1, 1));
        step(mk(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, 0));
        step(mk(1, 0, 5, 3'b000, 3'b000, 15'd0, 0, 0, -1, -1));
        step(mk(0, 0, 4, 3'b001, 3'b001, 15'd4, 0, 1, 1, 1));
        check("rst_wb_imul", 32'(wb_imul), 32'(0));
        check("rst_wb_rd", 32'(wb_rd_addr), 32'(0));
        for (int i = 0; i < 5; i++) step(mk(0, 0, 0, 3'b000, 3'b000, 15'd0, 0, 1, -1, -1));

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
